// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches 20-bit instruction words, decodes legal,
// illegal and halt opcodes, issues legal ones to the ALU controller and
// waits for completion, with a bounded wait that raises a sticky timeout.
module instr_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [19:0]       imem_data,
    output logic [3:0]        opcode,
    output logic [7:0]        operand_a,
    output logic [7:0]        operand_b,
    output logic              op,
    input  logic              acc_load,
    output logic              busy,
    output logic              halted,
    output logic              illegal,
    output logic              timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_ISSUE,
        S_WAIT,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [19:0]       ir_q, ir_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic              illegal_q, illegal_d;
    logic              timeout_q, timeout_d;

    // State and datapath registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            wcnt_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            wcnt_q    <= wcnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state and datapath updates; everything holds unless a state acts.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        wcnt_d    = wcnt_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d      = '0;
                    illegal_d = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                ir_d = imem_data;
                if (imem_data[19:16] == 4'hF) begin
                    state_d = S_HALT;
                end else if (imem_data[19:16] >= 4'd9) begin
                    illegal_d = 1'b1;
                    pc_d      = pc_q + ADDR_W'(1);
                    state_d   = S_FETCH;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Completion in the last permitted cycle still counts as success.
                if (acc_load) begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_FETCH;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                    if (wcnt_q == 4'(TIMEOUT - 1)) begin
                        timeout_d = 1'b1;
                        state_d   = S_HALT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign imem_addr = pc_q;
    assign opcode    = ir_q[19:16];
    assign operand_b = ir_q[15:8];
    assign operand_a = ir_q[7:0];
    assign op        = (state_q == S_ISSUE);
    assign busy      = (state_q == S_FETCH) || (state_q == S_LATCH) ||
                       (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign halted    = (state_q == S_HALT);
    assign illegal   = illegal_q;
    assign timeout   = timeout_q;

endmodule
